// File: rtl/axis_array_traffic_generator_if.sv
// AXIS bundle for the traffic generator array: one packed slice per port on every signal.
interface axis_array_traffic_generator_if #(
  parameter int unsigned NUM_PORTS  = 1,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned USER_WIDTH = 8
);
  logic [NUM_PORTS-1:0]                 tvalid;
  logic [NUM_PORTS-1:0]                 tready;
  logic [NUM_PORTS-1:0]                 tlast;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] tdata;
  logic [NUM_PORTS-1:0][DATA_WIDTH/8-1:0] tkeep;
  logic [NUM_PORTS-1:0][USER_WIDTH-1:0] tuser;

  modport master (output tvalid, tlast, tdata, tkeep, tuser, input tready);
  modport slave  (input tvalid, tlast, tdata, tkeep, tuser, output tready);
endinterface

// File: rtl/axis_array_traffic_generator.sv
// Multi-port AXIS traffic source: each port runs an independent counter FSM emitting bursts
// whose byte k of packet n is (n + k) mod 256, so sinks can regenerate data without storage.
module axis_array_traffic_generator #(
  parameter int unsigned NUM_PORTS     = 1,
  parameter int unsigned DATA_BYTES    = 8,
  parameter int unsigned MAX_LEN_BYTES = 9600,
  parameter int unsigned CNT_WIDTH     = 32,
  parameter int unsigned GAP_WIDTH     = 16,
  parameter int unsigned USER_WIDTH    = 8
) (
  input  logic                                 clk,
  input  logic                                 sreset,
  axis_array_traffic_generator_if.master       axis_packet_out,
  input  logic [NUM_PORTS-1:0]                 start,
  input  logic [NUM_PORTS-1:0]                 stop,
  input  logic [NUM_PORTS-1:0][15:0]           cfg_len_bytes,
  input  logic [NUM_PORTS-1:0][CNT_WIDTH-1:0]  cfg_num_packets,
  input  logic [NUM_PORTS-1:0][GAP_WIDTH-1:0]  cfg_gap_cycles,
  input  logic [NUM_PORTS-1:0][USER_WIDTH-1:0] cfg_user,
  output logic [NUM_PORTS-1:0]                 busy,
  output logic [NUM_PORTS-1:0][CNT_WIDTH-1:0]  packets_sent
);
  localparam int unsigned DataWidth = DATA_BYTES * 8;
  localparam logic [15:0] LaneBytes = 16'(DATA_BYTES);
  localparam logic [15:0] MaxLen    = 16'(MAX_LEN_BYTES);

  typedef enum logic [1:0] {StIdle, StSend, StGap} state_e;

  if (NUM_PORTS == 0) begin : g_bad_ports
    $error("NUM_PORTS must be greater than zero");
  end

  logic [NUM_PORTS-1:0]                 tvalid_all;
  logic [NUM_PORTS-1:0]                 tlast_all;
  logic [NUM_PORTS-1:0][DataWidth-1:0]  tdata_all;
  logic [NUM_PORTS-1:0][DATA_BYTES-1:0] tkeep_all;
  logic [NUM_PORTS-1:0][USER_WIDTH-1:0] tuser_all;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    state_e                state_q, state_d;
    logic [15:0]           len_q, len_d, rem_q, rem_d;
    logic [7:0]            off_q, off_d, pkt_q, pkt_d;
    logic [CNT_WIDTH-1:0]  num_q, num_d, sent_q, sent_d;
    logic [GAP_WIDTH-1:0]  gap_q, gap_d, gap_cnt_q, gap_cnt_d;
    logic [USER_WIDTH-1:0] user_q, user_d;
    logic                  stop_q, stop_d;
    logic                  last_beat;
    logic [15:0]           start_len;
    logic                  valid, last;
    logic [DataWidth-1:0]  data;
    logic [DATA_BYTES-1:0] keep;
    logic [USER_WIDTH-1:0] user;

    // rem_q counts bytes still to send in the packet, so the final beat needs no division.
    assign last_beat = rem_q <= LaneBytes;
    assign start_len = (cfg_len_bytes[p] > MaxLen) ? MaxLen : cfg_len_bytes[p];

    always_ff @(posedge clk) begin
      if (sreset) begin
        state_q   <= StIdle;
        len_q     <= '0;
        rem_q     <= '0;
        off_q     <= '0;
        pkt_q     <= '0;
        num_q     <= '0;
        sent_q    <= '0;
        gap_q     <= '0;
        gap_cnt_q <= '0;
        user_q    <= '0;
        stop_q    <= 1'b0;
      end else begin
        state_q   <= state_d;
        len_q     <= len_d;
        rem_q     <= rem_d;
        off_q     <= off_d;
        pkt_q     <= pkt_d;
        num_q     <= num_d;
        sent_q    <= sent_d;
        gap_q     <= gap_d;
        gap_cnt_q <= gap_cnt_d;
        user_q    <= user_d;
        stop_q    <= stop_d;
      end
    end

    always_comb begin
      state_d   = state_q;
      len_d     = len_q;
      rem_d     = rem_q;
      off_d     = off_q;
      pkt_d     = pkt_q;
      num_d     = num_q;
      sent_d    = sent_q;
      gap_d     = gap_q;
      gap_cnt_d = gap_cnt_q;
      user_d    = user_q;
      stop_d    = stop_q;
      case (state_q)
        StIdle: begin
          stop_d = 1'b0;
          if (start[p] && cfg_len_bytes[p] != '0) begin
            state_d = StSend;
            len_d   = start_len;
            rem_d   = start_len;
            off_d   = '0;
            pkt_d   = '0;
            num_d   = cfg_num_packets[p];
            gap_d   = cfg_gap_cycles[p];
            user_d  = cfg_user[p];
            sent_d  = '0;
            // A stop arriving with start is held until the first packet ends.
            stop_d  = stop[p];
          end
        end
        StSend: begin
          stop_d = stop_q | stop[p];
          if (axis_packet_out.tready[p]) begin
            if (last_beat) begin
              sent_d = sent_q + CNT_WIDTH'(1);
              pkt_d  = pkt_q + 8'd1;
              off_d  = '0;
              rem_d  = len_q;
              if (stop_q || stop[p] || (num_q != '0 && sent_d == num_q)) begin
                state_d = StIdle;
              end else if (gap_q != '0) begin
                state_d   = StGap;
                gap_cnt_d = gap_q;
              end
            end else begin
              off_d = off_q + 8'(DATA_BYTES);
              rem_d = rem_q - LaneBytes;
            end
          end
        end
        StGap: begin
          if (stop_q || stop[p]) begin
            state_d = StIdle;
          end else if (gap_cnt_q == GAP_WIDTH'(1)) begin
            state_d = StSend;
          end else begin
            gap_cnt_d = gap_cnt_q - GAP_WIDTH'(1);
          end
        end
        default: state_d = StIdle;
      endcase
    end

    // Outputs are forced to zero whenever no beat is offered.
    always_comb begin
      valid = (state_q == StSend);
      data  = '0;
      keep  = '0;
      last  = 1'b0;
      user  = '0;
      if (valid) begin
        last = last_beat;
        user = user_q;
        for (int i = 0; i < DATA_BYTES; i++) begin
          if (!last_beat || 16'(i) < rem_q) begin
            keep[i]        = 1'b1;
            data[8*i +: 8] = pkt_q + off_q + 8'(i);
          end
        end
      end
    end

    assign tvalid_all[p]   = valid;
    assign tlast_all[p]    = last;
    assign tdata_all[p]    = data;
    assign tkeep_all[p]    = keep;
    assign tuser_all[p]    = user;
    assign busy[p]         = (state_q != StIdle);
    assign packets_sent[p] = sent_q;
  end

  assign axis_packet_out.tvalid = tvalid_all;
  assign axis_packet_out.tlast  = tlast_all;
  assign axis_packet_out.tdata  = tdata_all;
  assign axis_packet_out.tkeep  = tkeep_all;
  assign axis_packet_out.tuser  = tuser_all;
endmodule

// File: tb/tb_axis_array_traffic_generator.sv
// Bench for axis_array_traffic_generator: a byte-level model regenerates every expected beat
// from (n + k) mod 256 while a random-tready sink checks stalls, gaps and packet counts.
module tb_axis_array_traffic_generator;
  localparam int NP     = 4;
  localparam int DB     = 8;
  localparam int MAXLEN = 9600;

  logic clk = 1'b0;
  logic sreset;
  always #5 clk = ~clk;

  logic [NP-1:0]        start, stop;
  logic [NP-1:0][15:0]  cfg_len_bytes;
  logic [NP-1:0][31:0]  cfg_num_packets;
  logic [NP-1:0][15:0]  cfg_gap_cycles;
  logic [NP-1:0][7:0]   cfg_user;
  logic [NP-1:0]        busy;
  logic [NP-1:0][31:0]  packets_sent;

  axis_array_traffic_generator_if #(.NUM_PORTS(NP), .DATA_WIDTH(DB*8), .USER_WIDTH(8)) axis_if ();

  axis_array_traffic_generator #(
    .NUM_PORTS(NP), .DATA_BYTES(DB), .MAX_LEN_BYTES(MAXLEN),
    .CNT_WIDTH(32), .GAP_WIDTH(16), .USER_WIDTH(8)
  ) dut (
    .clk(clk), .sreset(sreset), .axis_packet_out(axis_if),
    .start(start), .stop(stop), .cfg_len_bytes(cfg_len_bytes),
    .cfg_num_packets(cfg_num_packets), .cfg_gap_cycles(cfg_gap_cycles),
    .cfg_user(cfg_user), .busy(busy), .packets_sent(packets_sent)
  );

  int checks = 0;
  int errors = 0;

  // Model state per port: packet index n, byte offset k of the next beat, clamped length.
  int m_len[NP], m_user[NP], m_n[NP], m_k[NP];
  int gap_run[NP], exp_gap[NP], beats_seen[NP], ready_pct[NP];
  bit stalled[NP];
  logic [80:0] held[NP];

  typedef struct {
    int len; int num; int gap; int user; int pct; int exp_sent; int exp_beats;
  } vec_t;
  vec_t vecs[8];

  task automatic check_eq(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic monitor();
    bit rst_prev;
    rst_prev = 1'b0;
    forever begin
      @(negedge clk);
      for (int p = 0; p < NP; p++) begin
        logic        v, el;
        logic [80:0] beat, expb;
        logic [63:0] ed;
        logic [7:0]  ek;
        int          k;
        v    = axis_if.tvalid[p];
        beat = {axis_if.tdata[p], axis_if.tkeep[p], axis_if.tlast[p], axis_if.tuser[p]};
        if (stalled[p] && !rst_prev)
          check_eq($sformatf("stable p%0d", p), {v, beat}, {1'b1, held[p]});
        if (gap_run[p] >= 0) begin
          if (v) begin
            check_eq($sformatf("gap p%0d", p), gap_run[p], exp_gap[p]);
            gap_run[p] = -1;
          end else begin
            gap_run[p]++;
          end
        end
        axis_if.tready[p] = (ready_pct[p] >= 100) || ($urandom_range(0, 99) < ready_pct[p]);
        stalled[p] = 1'b0;
        if (v && axis_if.tready[p]) begin
          ed = '0;
          ek = '0;
          for (int i = 0; i < DB; i++) begin
            k = m_k[p] + i;
            if (k < m_len[p]) begin
              ek[i]          = 1'b1;
              ed[8*i +: 8]   = 8'((m_n[p] + k) % 256);
            end
          end
          el   = (m_k[p] + DB >= m_len[p]);
          expb = {ed, ek, el, 8'(m_user[p])};
          check_eq($sformatf("beat p%0d n%0d k%0d", p, m_n[p], m_k[p]), beat, expb);
          beats_seen[p]++;
          if (el) begin
            m_n[p]++;
            m_k[p]     = 0;
            gap_run[p] = 0;
          end else begin
            m_k[p] += DB;
          end
        end else if (v) begin
          stalled[p] = 1'b1;
          held[p]    = beat;
        end
      end
      rst_prev = sreset;
    end
  endtask

  task automatic model_arm(input int p, input int len, input int gap, input int user);
    m_len[p]      = (len > MAXLEN) ? MAXLEN : len;
    m_user[p]     = user;
    m_n[p]        = 0;
    m_k[p]        = 0;
    gap_run[p]    = -1;
    exp_gap[p]    = gap;
    beats_seen[p] = 0;
  endtask

  task automatic do_start(input int p, input int len, input int num, input int gap,
                          input int user, input bit accept, input bit with_stop,
                          input bit exp_busy);
    @(posedge clk);
    #1;
    cfg_len_bytes[p]   = 16'(len);
    cfg_num_packets[p] = 32'(num);
    cfg_gap_cycles[p]  = 16'(gap);
    cfg_user[p]        = 8'(user);
    start[p]           = 1'b1;
    stop[p]            = with_stop;
    if (accept) model_arm(p, len, gap, user);
    @(posedge clk);
    #1;
    start[p] = 1'b0;
    stop[p]  = 1'b0;
    check_eq($sformatf("start busy p%0d", p), busy[p], exp_busy);
    if (accept) check_eq($sformatf("first valid p%0d", p), axis_if.tvalid[p], 1'b1);
  endtask

  task automatic wait_idle(input int p, input int budget);
    for (int c = 0; c < budget && busy[p]; c++) begin
      @(posedge clk);
      #1;
    end
    check_eq($sformatf("idle p%0d", p), busy[p], 1'b0);
  endtask

  task automatic pulse_stop(input int p);
    stop[p] = 1'b1;
    @(posedge clk);
    #1;
    stop[p] = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int l, n;
    bit found;
    int mp_len[NP], mp_num[NP], mp_gap[NP], mp_pct[NP];
    int saved_sent;

    sreset          = 1'b1;
    start           = '0;
    stop            = '0;
    cfg_len_bytes   = '0;
    cfg_num_packets = '0;
    cfg_gap_cycles  = '0;
    cfg_user        = '0;
    axis_if.tready  = '0;
    for (int p = 0; p < NP; p++) begin
      model_arm(p, 0, 0, 0);
      stalled[p]   = 1'b0;
      ready_pct[p] = 100;
    end
    repeat (3) @(posedge clk);
    #1;
    sreset = 1'b0;
    for (int p = 0; p < NP; p++)
      check_eq($sformatf("reset outputs p%0d", p),
               {axis_if.tvalid[p], axis_if.tlast[p], axis_if.tkeep[p], axis_if.tdata[p],
                axis_if.tuser[p], busy[p], packets_sent[p]}, '0);
    fork
      monitor();
    join_none

    // len, num, gap, user, tready%, expected packets, expected beats
    vecs[0] = '{20,    1,  0, 'hA5, 100, 1,  3};
    vecs[1] = '{16,    3,  4, 'h3C, 100, 3,  6};
    vecs[2] = '{65,    10, 0, 'h11, 50,  10, 90};
    vecs[3] = '{10000, 1,  2, 'hE7, 100, 1,  1200};
    vecs[4] = '{1,     4,  1, 'h02, 70,  4,  4};
    vecs[5] = '{8,     2,  0, 'hFF, 50,  2,  2};
    for (int i = 6; i < 8; i++) begin
      l = $urandom_range(1, 100);
      n = $urandom_range(1, 5);
      vecs[i] = '{l, n, $urandom_range(0, 5), $urandom_range(0, 255), $urandom_range(30, 100),
                  n, n * ((l + DB - 1) / DB)};
    end
    for (int i = 0; i < 8; i++) begin
      ready_pct[0] = vecs[i].pct;
      do_start(0, vecs[i].len, vecs[i].num, vecs[i].gap, vecs[i].user, 1'b1, 1'b0, 1'b1);
      wait_idle(0, 20000);
      check_eq($sformatf("vec%0d sent", i), packets_sent[0], vecs[i].exp_sent);
      check_eq($sformatf("vec%0d beats", i), beats_seen[0], vecs[i].exp_beats);
    end

    // Zero-length start is ignored and leaves status alone.
    ready_pct[0] = 100;
    saved_sent   = vecs[7].exp_sent;
    do_start(0, 0, 5, 0, 'h10, 1'b0, 1'b0, 1'b0);
    check_eq("len0 sent", packets_sent[0], saved_sent);
    check_eq("len0 valid", axis_if.tvalid[0], 1'b0);

    // Start while busy is ignored; stream keeps the first configuration.
    do_start(0, 40, 2, 3, 'h5A, 1'b1, 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    do_start(0, 7, 1, 0, 'h77, 1'b0, 1'b0, 1'b1);
    wait_idle(0, 200);
    check_eq("busy-start sent", packets_sent[0], 2);
    check_eq("busy-start beats", beats_seen[0], 10);

    // Infinite mode, stop during beat 2 of packet 5.
    do_start(0, 20, 0, 0, 'h33, 1'b1, 1'b0, 1'b1);
    found = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      if (m_n[0] == 5 && m_k[0] == DB) found = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    check_eq("stop window", found, 1'b1);
    pulse_stop(0);
    wait_idle(0, 50);
    check_eq("stop sent", packets_sent[0], 6);
    check_eq("stop model pkts", m_n[0], 6);
    repeat (10) @(posedge clk);
    #1;
    check_eq("stop no more beats", beats_seen[0], 18);

    // Start and stop together: exactly one packet.
    do_start(0, 12, 0, 2, 'h44, 1'b1, 1'b1, 1'b1);
    wait_idle(0, 50);
    check_eq("start+stop sent", packets_sent[0], 1);
    check_eq("start+stop beats", beats_seen[0], 2);

    // Stop during the gap ends the burst on the next cycle.
    do_start(0, 8, 0, 10, 'h55, 1'b1, 1'b0, 1'b1);
    for (int c = 0; c < 50 && packets_sent[0] != 1; c++) begin
      @(posedge clk);
      #1;
    end
    repeat (2) @(posedge clk);
    #1;
    pulse_stop(0);
    check_eq("gap stop busy", busy[0], 1'b0);
    check_eq("gap stop sent", packets_sent[0], 1);
    check_eq("gap stop beats", beats_seen[0], 1);

    // Four independent ports, finite bursts.
    mp_len = '{5, 17, 33, 64};
    mp_num = '{3, 4, 2, 5};
    mp_gap = '{0, 2, 1, 3};
    mp_pct = '{100, 60, 80, 40};
    @(posedge clk);
    #1;
    for (int p = 0; p < NP; p++) begin
      ready_pct[p]       = mp_pct[p];
      cfg_len_bytes[p]   = 16'(mp_len[p]);
      cfg_num_packets[p] = 32'(mp_num[p]);
      cfg_gap_cycles[p]  = 16'(mp_gap[p]);
      cfg_user[p]        = 8'(16 * p + 1);
      model_arm(p, mp_len[p], mp_gap[p], 16 * p + 1);
    end
    start = '1;
    @(posedge clk);
    #1;
    start = '0;
    for (int p = 0; p < NP; p++) begin
      wait_idle(p, 2000);
      check_eq($sformatf("multi sent p%0d", p), packets_sent[p], mp_num[p]);
      check_eq($sformatf("multi beats p%0d", p), beats_seen[p],
               mp_num[p] * ((mp_len[p] + DB - 1) / DB));
    end

    // Infinite on all ports, then reset mid-packet.
    @(posedge clk);
    #1;
    for (int p = 0; p < NP; p++) begin
      cfg_num_packets[p] = '0;
      model_arm(p, mp_len[p], mp_gap[p], 16 * p + 1);
    end
    start = '1;
    @(posedge clk);
    #1;
    start = '0;
    repeat (37) @(posedge clk);
    #1;
    for (int p = 0; p < NP; p++)
      check_eq($sformatf("multi running p%0d", p), beats_seen[p] > 0, 1'b1);
    sreset = 1'b1;
    @(posedge clk);
    #1;
    sreset = 1'b0;
    for (int p = 0; p < NP; p++)
      check_eq($sformatf("mid reset p%0d", p),
               {axis_if.tvalid[p], axis_if.tlast[p], axis_if.tkeep[p], axis_if.tdata[p],
                axis_if.tuser[p], busy[p], packets_sent[p]}, '0);
    repeat (5) @(posedge clk);
    #1;
    for (int p = 0; p < NP; p++)
      check_eq($sformatf("post reset idle p%0d", p), {axis_if.tvalid[p], busy[p]}, 2'b00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
